ka_dat_arbiter: RTL
===================

Name: ka_dat_arbiter

Overview:
- Round-robin arbiter that shares one ka decode datapath between NREQ requesters.
- Each requester presents a t_ka_dat word (selector field on top, SLICES address slices below) with a valid/ready handshake.
- Winning word is registered and forwarded to the downstream ka_decode_dat instance with source tag; one word per cycle at full throughput.

Parameters:
- SELOU, 4, selector field width (top bits of word).
- SLICES, 4, number of address slices.
- BADDR, 8, width of one address slice.
- NREQ, 4, number of requesters (2..16).
- Derived: W = SELOU + SLICES*BADDR (36 at defaults); SW = clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester word valid.
- req_dat  in  NREQ*W  requester i word at bits [i*W +: W].
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- t_ka_dat  out  W  registered word to decode block.
- t_ka_valid  out  1  t_ka_dat valid.
- t_ka_ready  in  1  downstream accept.
- t_ka_src  out  SW  index of requester that supplied t_ka_dat.
- locked  out  1  high while a lock burst owns the arbiter (always 0 when feature compiled out).

Behaviour:
- Reset (asynchronous, reset_n low): t_ka_valid=0, t_ka_dat=0, t_ka_src=0, locked=0, rr pointer=0, state=ARB. req_ready is combinational and is 0 while t_ka_valid=0 is not sufficient to force it; req_ready=0 during reset.
- Space: space = !t_ka_valid | t_ka_ready.
- Grant, state ARB: winner = first i with req_valid[i], searching from rr pointer upward, modulo NREQ. req_ready[winner] = space; all other bits 0. req_ready is combinational from req_valid, state and space only, never from req_dat.
- Transfer: req_valid[i] & req_ready[i]. Next edge: t_ka_dat <= word i, t_ka_src <= i, t_ka_valid <= 1, rr pointer <= (i+1) mod NREQ.
- Drain: if t_ka_valid & t_ka_ready and no transfer, t_ka_valid <= 0 next edge. Simultaneous drain and transfer: register reloads, t_ka_valid stays 1, no bubble.
- Latency: word accepted at edge N is presented at edge N+1.
- Stall: while t_ka_valid & !t_ka_ready, t_ka_dat and t_ka_src hold stable and all req_ready=0.
- No requesters valid: rr pointer unchanged.
- A requester that drops req_valid before being granted loses nothing; the arbiter carries no per-requester state.
- Reset mid-operation: the registered word is discarded and the pointer returns to 0.

Optional Feature:
- Macro: KA_DAT_ARB_LOCK_EN.
- Defined: selector bit t_ka word[W-1] is a lock bit.
  - Accepting a word with lock bit=1 moves state ARB->LOCKED with owner=i; locked=1 from the next edge.
  - In LOCKED, only the owner may be granted (req_ready[owner]=space) and the rr pointer is frozen.
  - Accepting an owner word with lock bit=0 returns state to ARB, sets locked=0, and sets pointer to owner+1.
  - Lock bit has no effect on data; the word is forwarded unmodified.
- Undefined: no LOCKED state, locked tied 0, every word rearbitrates.

Test Plan:
- Single requester: req_valid=4'b0010, word 36'h1_2345_6789, t_ka_ready=1 -> req_ready=4'b0010; next cycle t_ka_dat=36'h1_2345_6789, t_ka_src=1, t_ka_valid=1.
- Fairness: all four valid continuously, t_ka_ready=1 for 8 cycles -> t_ka_src sequence 0,1,2,3,0,1,2,3 with t_ka_valid=1 every cycle, no bubbles.
- Backpressure: t_ka_ready=0 for 5 cycles with word 36'hA_0000_00FF held -> t_ka_dat stable, req_ready=0; on the release cycle a new word is accepted in the same cycle.
- Async reset: assert reset_n low mid-cycle while t_ka_valid=1 -> t_ka_valid=0 immediately, without waiting for a clk edge; after release the first grant goes to requester 0 when all are valid.
- Lock, with KA_DAT_ARB_LOCK_EN: requester 2 sends 36'h8_xxxx_xxxx, 36'h8_..., 36'h0_... while all requesters are valid -> t_ka_src=2,2,2 and locked=1,1,0; the next grant goes to 3.
- Lock word, without KA_DAT_ARB_LOCK_EN: same stimulus -> t_ka_src=2,3,0 and locked=0 throughout.

Source files
------------

// File: rtl/ka_dat_arbiter.sv
// ka_dat_arbiter
//   Round-robin arbiter that shares one ka decode datapath between NREQ
//   requesters. The winning word is registered and forwarded with its
//   source index. It sustains one word per cycle.
//
//   Handshake: a word moves on a rising clk edge when valid and ready are
//   both high on that interface. Once valid is asserted, the upstream side
//   holds its word until it is accepted. The decode-side output register
//   reloads in the same cycle it drains, so a full pipeline has no bubbles.
//
//   Optional feature (macro KA_DAT_ARB_LOCK_EN):
//     The top word bit (word[W-1]) becomes a lock bit. Accepting a word that
//     has the lock bit set lets that requester own the arbiter until it sends
//     a word with the lock bit clear. Without the macro, locked is tied to 0
//     and every word is arbitrated again.
//
// Ports:
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   [NREQ]     per-requester word valid
//   req_dat     in   [NREQ*W]   requester i word at bits [i*W +: W]
//   req_ready   out  [NREQ]     per-requester accept, one-hot or zero
//   t_ka_dat    out  [W]        registered word to the decode block
//   t_ka_valid  out             t_ka_dat valid
//   t_ka_ready  in              downstream accept
//   t_ka_src    out  [SW]       index of the requester that supplied t_ka_dat
//   locked      out             a lock burst owns the arbiter
//   dbg_state   out             FSM state (0 = ARB, 1 = LOCKED)
module ka_dat_arbiter #(
    parameter int SELOU  = 4,
    parameter int SLICES = 4,
    parameter int BADDR  = 8,
    parameter int NREQ   = 4,
    localparam int W     = SELOU + SLICES * BADDR,
    localparam int SW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_dat,
    output logic [NREQ-1:0]     req_ready,
    output logic [W-1:0]        t_ka_dat,
    output logic                t_ka_valid,
    input  logic                t_ka_ready,
    output logic [SW-1:0]       t_ka_src,
    output logic                locked,
    output logic                dbg_state
);

    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   ptr_d;
    logic [NREQ-1:0] eligible;
    logic [SW-1:0]   win;
    logic            found;
    logic            space;
    logic            grant_ok;
    logic [W-1:0]    win_word;
    logic [SW-1:0]   ptr_inc;

    // The output register can take a word when it is empty or is draining now.
    assign space    = !t_ka_valid || t_ka_ready;
    // reset_n gates the grant so no requester sees ready while the arbiter is in reset.
    assign grant_ok = found && space && reset_n;
    assign win_word = req_dat[win*W +: W];
    assign ptr_inc  = (win == SW'(NREQ - 1)) ? '0 : win + 1'b1;

`ifdef KA_DAT_ARB_LOCK_EN
    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;
    state_t        state_q, state_d;
    logic [SW-1:0] owner_q;
    logic          lock_bit;

    assign lock_bit = win_word[W-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (grant_ok && lock_bit)  state_d = LOCKED;
            LOCKED:  if (grant_ok && !lock_bit) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && grant_ok && lock_bit)
                owner_q <= win;
        end
    end

    // While LOCKED, only the owner is eligible.
    always_comb begin
        eligible = req_valid;
        if (state_q == LOCKED)
            eligible = req_valid & (NREQ'(1) << owner_q);
    end

    // The pointer is frozen during a burst. On the closing word win == owner,
    // so ptr_inc equals owner+1.
    always_comb begin
        ptr_d = rr_ptr;
        if (grant_ok && (state_q == ARB || !lock_bit))
            ptr_d = ptr_inc;
    end

    assign locked    = (state_q == LOCKED);
    assign dbg_state = state_q;
`else
    assign eligible  = req_valid;
    assign locked    = 1'b0;
    assign dbg_state = 1'b0;

    always_comb begin
        ptr_d = rr_ptr;
        if (grant_ok)
            ptr_d = ptr_inc;
    end
`endif

    // Pick the first eligible requester, searching upward from rr_ptr with wrap.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    assign req_ready = grant_ok ? (NREQ'(1) << win) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_ka_dat   <= '0;
            t_ka_src   <= '0;
            t_ka_valid <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            if (grant_ok) begin
                t_ka_dat   <= win_word;
                t_ka_src   <= win;
                t_ka_valid <= 1'b1;
            end else if (t_ka_ready) begin
                t_ka_valid <= 1'b0;
            end
            rr_ptr <= ptr_d;
        end
    end

endmodule
